heap_pair_writer: RTL and testbench

Loads one sorted frame of 256 byte-wide elements into the even/odd heap RAM pair. It is the write-side partner of the heap storage block: it drives the `heap_even_*` and `heap_odd_*` write ports so that element k lands in bank k[0] at address k[7:1]. That placement lets the reader fetch min-first as `{even[j], odd[j], even[j+1], odd[j+1]}` and max-first from address 0x7F downward. It sits between the sorter's ascending byte stream and the heap storage, and tells the bit-length generator when the heap is full.

---
 rtl/heap_pair_writer.sv | 221 ++++++++++++++++++++++
 tb/tb_heap_pair_writer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_pair_writer.sv
// heap_pair_writer: packs one ascending 256-byte frame into the even/odd heap RAM pair
// (element k -> bank k[0], address k[7:1]). Optional HEAP_WR_PAD_EN pads short frames with 0xFF.
module heap_pair_writer (
    input  logic       clk,
    input  logic       rstN,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       heap_even_wea,
    output logic [6:0] heap_even_addra,
    output logic [7:0] heap_even_dina,
    output logic       heap_odd_wea,
    output logic [6:0] heap_odd_addra,
    output logic [7:0] heap_odd_dina,
    output logic       heap_even_web,
    output logic       heap_odd_web,
    output logic [6:0] heap_even_addrb,
    output logic [6:0] heap_odd_addrb,
    output logic [7:0] heap_even_dinb,
    output logic [7:0] heap_odd_dinb,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
`ifdef HEAP_WR_PAD_EN
    localparam logic [1:0] ST_PAD    = 2'd2;
`endif
    localparam logic [1:0] ST_FIN    = 2'd3;
    localparam logic [7:0] PAD_BYTE  = 8'hFF;
    localparam logic [6:0] LAST_ADDR = 7'd127;

    logic [1:0] state_r,     state_n;
    logic [8:0] elem_cnt_r,  elem_cnt_n;
    logic [7:0] even_hold_r, even_hold_n;
    logic [7:0] prev_r,      prev_n;
    logic [1:0] err_r,       err_n;
    logic       wr_en_r,     wr_en_n;
    logic [6:0] wr_addr_r,   wr_addr_n;
    logic [7:0] wr_even_r,   wr_even_n;
    logic [7:0] wr_odd_r,    wr_odd_n;
    logic       done_r,      done_n;
    logic       busy_r,      busy_n;
    logic       in_ready_r,  in_ready_n;
`ifdef HEAP_WR_PAD_EN
    logic [6:0] pad_addr_r,  pad_addr_n;
`endif
    logic       acc_s;

    assign acc_s = in_valid & in_ready_r;

    // Next-state and next-output computation for the frame loader
    always_comb begin
        state_n     = state_r;
        elem_cnt_n  = elem_cnt_r;
        even_hold_n = even_hold_r;
        prev_n      = prev_r;
        err_n       = err_r;
        wr_en_n     = 1'b0;
        wr_addr_n   = wr_addr_r;
        wr_even_n   = wr_even_r;
        wr_odd_n    = wr_odd_r;
        done_n      = 1'b0;
        in_ready_n  = in_ready_r;
`ifdef HEAP_WR_PAD_EN
        pad_addr_n  = pad_addr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n    = ST_FILL;
                    elem_cnt_n = 9'd0;
                    err_n      = 2'b00;
                    prev_n     = 8'd0;
                    in_ready_n = 1'b1;
                end else begin
                    state_n    = ST_IDLE;
                    in_ready_n = 1'b0;
                end
            end
            ST_FILL: begin
                if (acc_s) begin
                    elem_cnt_n = elem_cnt_r + 9'd1;
                    prev_n     = in_data;
                    if ((elem_cnt_r != 9'd0) && (in_data < prev_r)) begin
                        err_n[1] = 1'b1;
                    end else begin
                        err_n[1] = err_r[1];
                    end
                    // Even elements wait in even_hold until their odd partner arrives
                    if (!elem_cnt_r[0]) begin
                        even_hold_n = in_data;
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = elem_cnt_r[7:1];
                        wr_even_n = even_hold_r;
                        wr_odd_n  = in_data;
                    end
                    if (elem_cnt_r[7:0] == 8'd255) begin
                        in_ready_n = 1'b0;
                        state_n    = ST_FIN;
                        if (!in_last) begin
                            err_n[0] = 1'b1;
                        end else begin
                            err_n[0] = err_r[0];
                        end
                    end else if (in_last) begin
                        in_ready_n = 1'b0;
                        // A dangling even element is flushed with a 0xFF odd partner
                        if (!elem_cnt_r[0]) begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = elem_cnt_r[7:1];
                            wr_even_n = in_data;
                            wr_odd_n  = PAD_BYTE;
                        end else begin
                            wr_en_n   = 1'b1;
                        end
`ifdef HEAP_WR_PAD_EN
                        if (elem_cnt_r[7:1] == LAST_ADDR) begin
                            state_n = ST_FIN;
                        end else begin
                            state_n    = ST_PAD;
                            pad_addr_n = elem_cnt_r[7:1] + 7'd1;
                        end
`else
                        state_n  = ST_FIN;
                        err_n[0] = 1'b1;
`endif
                    end else begin
                        state_n = ST_FILL;
                    end
                end else begin
                    state_n = ST_FILL;
                end
            end
`ifdef HEAP_WR_PAD_EN
            ST_PAD: begin
                wr_en_n    = 1'b1;
                wr_addr_n  = pad_addr_r;
                wr_even_n  = PAD_BYTE;
                wr_odd_n   = PAD_BYTE;
                in_ready_n = 1'b0;
                if (pad_addr_r == LAST_ADDR) begin
                    state_n = ST_FIN;
                end else begin
                    pad_addr_n = pad_addr_r + 7'd1;
                end
            end
`endif
            ST_FIN: begin
                done_n     = 1'b1;
                state_n    = ST_IDLE;
                in_ready_n = 1'b0;
            end
            default: begin
                state_n    = ST_IDLE;
                in_ready_n = 1'b0;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // State and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r     <= ST_IDLE;
            elem_cnt_r  <= 9'd0;
            even_hold_r <= 8'd0;
            prev_r      <= 8'd0;
            err_r       <= 2'b00;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= 7'd0;
            wr_even_r   <= 8'd0;
            wr_odd_r    <= 8'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
`ifdef HEAP_WR_PAD_EN
            pad_addr_r  <= 7'd0;
`endif
        end else begin
            state_r     <= state_n;
            elem_cnt_r  <= elem_cnt_n;
            even_hold_r <= even_hold_n;
            prev_r      <= prev_n;
            err_r       <= err_n;
            wr_en_r     <= wr_en_n;
            wr_addr_r   <= wr_addr_n;
            wr_even_r   <= wr_even_n;
            wr_odd_r    <= wr_odd_n;
            done_r      <= done_n;
            busy_r      <= busy_n;
            in_ready_r  <= in_ready_n;
`ifdef HEAP_WR_PAD_EN
            pad_addr_r  <= pad_addr_n;
`endif
        end
    end

    assign in_ready        = in_ready_r;
    assign heap_even_wea   = wr_en_r;
    assign heap_even_addra = wr_addr_r;
    assign heap_even_dina  = wr_even_r;
    assign heap_odd_wea    = wr_en_r;
    assign heap_odd_addra  = wr_addr_r;
    assign heap_odd_dina   = wr_odd_r;
    assign heap_even_web   = 1'b0;
    assign heap_odd_web    = 1'b0;
    assign heap_even_addrb = 7'd0;
    assign heap_odd_addrb  = 7'd0;
    assign heap_even_dinb  = 8'd0;
    assign heap_odd_dinb   = 8'd0;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;

endmodule

// File: tb/tb_heap_pair_writer.sv
// Self-checking bench for heap_pair_writer: captured pair writes are compared against
// a frame-level model that places element k in slot k and pads missing slots with 0xFF.
module tb_heap_pair_writer;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready, busy, done;
    logic       heap_even_wea, heap_odd_wea, heap_even_web, heap_odd_web;
    logic [6:0] heap_even_addra, heap_odd_addra, heap_even_addrb, heap_odd_addrb;
    logic [7:0] heap_even_dina, heap_odd_dina, heap_even_dinb, heap_odd_dinb;
    logic [1:0] err;
    logic [68:0] all_outs;

    heap_pair_writer dut (
        .clk(clk), .rstN(rstN), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready),
        .heap_even_wea(heap_even_wea), .heap_even_addra(heap_even_addra), .heap_even_dina(heap_even_dina),
        .heap_odd_wea(heap_odd_wea), .heap_odd_addra(heap_odd_addra), .heap_odd_dina(heap_odd_dina),
        .heap_even_web(heap_even_web), .heap_odd_web(heap_odd_web),
        .heap_even_addrb(heap_even_addrb), .heap_odd_addrb(heap_odd_addrb),
        .heap_even_dinb(heap_even_dinb), .heap_odd_dinb(heap_odd_dinb),
        .busy(busy), .done(done), .err(err)
    );

    assign all_outs = {in_ready, heap_even_wea, heap_even_addra, heap_even_dina, heap_odd_wea,
                       heap_odd_addra, heap_odd_dina, heap_even_web, heap_odd_web, heap_even_addrb,
                       heap_odd_addrb, heap_even_dinb, heap_odd_dinb, busy, done, err};

`ifdef HEAP_WR_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] stim [256];
    int wa_q[$], we_q[$], wo_q[$], wc_q[$], done_q[$];
    int ea_q[$], ee_q[$], eo_q[$];
    logic [1:0] exp_err;
    int bad_ready = 0, bad_portb = 0, bad_strobe = 0;
    int n_checks = 0, n_fail = 0;

    // Passive monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (in_ready && !busy) bad_ready <= bad_ready + 1;
        if (heap_even_web || heap_odd_web || (heap_even_addrb != 7'd0) || (heap_odd_addrb != 7'd0) ||
            (heap_even_dinb != 8'd0) || (heap_odd_dinb != 8'd0)) bad_portb <= bad_portb + 1;
        if (heap_even_wea || heap_odd_wea) begin
            if (!(heap_even_wea && heap_odd_wea && heap_even_addra == heap_odd_addra))
                bad_strobe <= bad_strobe + 1;
            wa_q.push_back(int'(heap_even_addra));
            we_q.push_back(int'(heap_even_dina));
            wo_q.push_back(int'(heap_odd_dina));
            wc_q.push_back(cyc);
        end
        if (done) done_q.push_back(cyc);
    end

    // Frame model: slot k holds element k, unfilled slots read 0xFF
    function automatic void build_exp(int n, bit with_last);
        logic [7:0] h [256];
        int np;
        ea_q.delete(); ee_q.delete(); eo_q.delete();
        for (int k = 0; k < 256; k++) h[k] = (k < n) ? stim[k] : 8'hFF;
        np = (n == 256 || PAD_ON) ? 128 : (n + 1) / 2;
        for (int j = 0; j < np; j++) begin
            ea_q.push_back(j); ee_q.push_back(int'(h[2*j])); eo_q.push_back(int'(h[2*j+1]));
        end
        exp_err = 2'b00;
        for (int i = 1; i < n; i++) if (stim[i] < stim[i-1]) exp_err[1] = 1'b1;
        exp_err[0] = (n == 256) ? !with_last : !PAD_ON;
    endfunction

    function automatic int first_mismatch();
        for (int i = 0; i < ea_q.size(); i++) begin
            if (i >= wa_q.size()) return i;
            if (wa_q[i] != ea_q[i] || we_q[i] != ee_q[i] || wo_q[i] != eo_q[i]) return i;
        end
        if (wa_q.size() > ea_q.size()) return ea_q.size();
        return -1;
    endfunction

    function automatic bit done_ok(bit seen);
        return seen && done_q.size() == 1 && wc_q.size() > 0 && done_q[0] == wc_q[wc_q.size()-1] + 1;
    endfunction

    task automatic clear_mon();
        wa_q.delete(); we_q.delete(); wo_q.delete(); wc_q.delete(); done_q.delete();
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_elems(int n, bit with_last, bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; @(negedge clk); end
            end
            in_valid = 1'b1; in_data = stim[i]; in_last = with_last && (i == n - 1);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        for (int i = 0; i < 600 && done_q.size() == 0; i++) @(negedge clk);
        seen = (done_q.size() > 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_ascending();
        for (int i = 0; i < 256; i++) stim[i] = 8'(i);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_outs !== 69'd0) begin n_fail++; $display("FAIL reset_outs: got %h need 0", all_outs); end
        rstN = 1'b1;
        @(negedge clk);
        n_checks++;
        if (all_outs !== 69'd0) begin n_fail++; $display("FAIL idle_outs: got %h need 0", all_outs); end
    endtask

    task automatic test_full_frame();
        bit seen; int mis;
        fill_ascending(); clear_mon();
        do_start();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_start: in_ready=%b busy=%b need 1 1", in_ready, busy);
        end
        send_elems(256, 1'b1, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_drop: in_ready=%b need 0", in_ready); end
        wait_done(seen);
        build_exp(256, 1'b1); mis = first_mismatch();
        n_checks++;
        if (mis != -1) begin
            n_fail++; $display("FAIL full_writes: first diff at strobe %0d, got %0d strobes need %0d", mis, wa_q.size(), ea_q.size());
        end
        n_checks++;
        if (err !== exp_err) begin n_fail++; $display("FAIL full_err: got %b need %b", err, exp_err); end
        n_checks++;
        if (!done_ok(seen)) begin n_fail++; $display("FAIL full_done: done count %0d, need 1 pulse one cycle after last strobe", done_q.size()); end
    endtask

    task automatic test_gaps();
        bit seen; int mis;
        fill_ascending(); clear_mon();
        bad_ready = 0; bad_portb = 0; bad_strobe = 0;
        do_start();
        send_elems(256, 1'b1, 1'b1);
        wait_done(seen);
        build_exp(256, 1'b1); mis = first_mismatch();
        n_checks++;
        if (mis != -1) begin
            n_fail++; $display("FAIL gap_writes: first diff at strobe %0d, got %0d strobes need %0d", mis, wa_q.size(), ea_q.size());
        end
        n_checks++;
        if (!done_ok(seen) || err !== exp_err) begin
            n_fail++; $display("FAIL gap_done_err: done count %0d err %b need 1 and %b", done_q.size(), err, exp_err);
        end
        n_checks++;
        if (bad_ready != 0 || bad_portb != 0 || bad_strobe != 0) begin
            n_fail++; $display("FAIL gap_side: ready %0d portb %0d strobe %0d bad cycles, need 0", bad_ready, bad_portb, bad_strobe);
        end
    endtask

    task automatic test_early_end();
        bit seen; int mis;
        for (int i = 0; i < 5; i++) stim[i] = 8'(10 * (i + 1));
        clear_mon();
        do_start();
        send_elems(5, 1'b1, 1'b0);
        wait_done(seen);
        build_exp(5, 1'b1); mis = first_mismatch();
        n_checks++;
        if (mis != -1) begin
            n_fail++; $display("FAIL early_writes: first diff at strobe %0d, got %0d strobes need %0d", mis, wa_q.size(), ea_q.size());
        end
        n_checks++;
        if (err !== exp_err) begin n_fail++; $display("FAIL early_err: got %b need %b", err, exp_err); end
        n_checks++;
        if (!done_ok(seen)) begin n_fail++; $display("FAIL early_done: done count %0d", done_q.size()); end
    endtask

    task automatic test_order();
        bit seen; int mis;
        stim[0] = 8'd5; stim[1] = 8'd3;
        for (int i = 2; i < 256; i++) stim[i] = 8'($urandom_range(0, 255));
        clear_mon();
        do_start();
        send_elems(256, 1'b1, 1'b0);
        wait_done(seen);
        build_exp(256, 1'b1); mis = first_mismatch();
        n_checks++;
        if (mis != -1) begin
            n_fail++; $display("FAIL order_writes: first diff at strobe %0d, got %0d strobes need %0d", mis, wa_q.size(), ea_q.size());
        end
        n_checks++;
        if (err !== exp_err) begin n_fail++; $display("FAIL order_err: got %b need %b", err, exp_err); end
        n_checks++;
        if (we_q.size() == 0 || we_q[0] != 5 || wo_q[0] != 3) begin
            n_fail++; $display("FAIL order_pair0: got %0d strobes, need even 5 odd 3 at addr 0", we_q.size());
        end
    endtask

    task automatic test_short_random();
        bit seen; int mis; int n; int v;
        for (int t = 0; t < 3; t++) begin
            n = (t == 0) ? 1 : (t == 1) ? 255 : $urandom_range(2, 254);
            v = $urandom_range(0, 20);
            for (int i = 0; i < 256; i++) begin
                stim[i] = 8'(v);
                v = (v + $urandom_range(0, 1) > 255) ? 255 : v + $urandom_range(0, 1);
            end
            clear_mon();
            do_start();
            send_elems(n, 1'b1, 1'b1);
            wait_done(seen);
            build_exp(n, 1'b1); mis = first_mismatch();
            n_checks++;
            if (mis != -1 || err !== exp_err || !done_ok(seen)) begin
                n_fail++; $display("FAIL short_n%0d: diff at %0d, strobes %0d need %0d, err %b need %b, done %0d",
                                   n, mis, wa_q.size(), ea_q.size(), err, exp_err, done_q.size());
            end
        end
    endtask

    task automatic test_overrun();
        bit seen; int mis;
        fill_ascending(); clear_mon();
        do_start();
        send_elems(256, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL overrun_ready: in_ready=%b need 0", in_ready); end
        repeat (3) @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        wait_done(seen);
        build_exp(256, 1'b0); mis = first_mismatch();
        n_checks++;
        if (mis != -1) begin
            n_fail++; $display("FAIL overrun_writes: first diff at strobe %0d, got %0d strobes need %0d", mis, wa_q.size(), ea_q.size());
        end
        n_checks++;
        if (err !== exp_err || !done_ok(seen)) begin
            n_fail++; $display("FAIL overrun_err: err %b need %b, done count %0d", err, exp_err, done_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        bit seen; int mis;
        fill_ascending(); clear_mon();
        do_start();
        send_elems(40, 1'b0, 1'b0);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== 69'd0) begin n_fail++; $display("FAIL midreset_outs: got %h need 0", all_outs); end
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (wa_q.size() != 20 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_abort: %0d strobes busy %b, need 20 and 0", wa_q.size(), busy);
        end
        clear_mon();
        do_start();
        send_elems(256, 1'b1, 1'b0);
        wait_done(seen);
        build_exp(256, 1'b1); mis = first_mismatch();
        n_checks++;
        if (mis != -1 || err !== 2'b00 || !done_ok(seen)) begin
            n_fail++; $display("FAIL midreset_restart: diff at %0d, strobes %0d, err %b need 00", mis, wa_q.size(), err);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_early_end();
        test_order();
        test_short_random();
        test_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
